// File: rtl/oam_dma_arbiter_pkg.sv
// oam_dma_arbiter_pkg
// Shared types and constants for the OAM DMA engine and the OAM port arbiter.
//   ppu_mode_t   : PPU STAT[1:0] modes
//   oam_owner_t  : which requester drives the OAM port in a given clock
//   OAM_BASE/OAM_END/DMA_REG_ADDR : address map constants
//   ST_*         : DMA engine FSM encodings
//   fold_src_hi  : maps an FF46 value onto the source high byte (echo RAM fold)
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        MODE_0 = 2'd0,  // HBlank
        MODE_1 = 2'd1,  // VBlank
        MODE_2 = 2'd2,  // OAM search
        MODE_3 = 2'd3   // pixel transfer
    } ppu_mode_t;

    typedef enum logic [1:0] {
        OWN_DMA = 2'd0,
        OWN_PPU = 2'd1,
        OWN_CPU = 2'd2
    } oam_owner_t;

    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] OAM_END      = 16'hFE9F;
    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DELAY = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_PAD   = 3'd5;

    // Sources at or above 0xE0 land in echo RAM; fold them down onto WRAM.
    function automatic logic [7:0] fold_src_hi(input logic [7:0] reg_val);
        return (reg_val < 8'hE0) ? reg_val : reg_val - 8'h20;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_engine.sv
// oam_dma_engine
// Sequencer for one 160-byte OAM DMA transfer: start delay, then per byte
// READ (src_rd) -> WAIT (source latency) -> WRITE (one OAM write) -> PAD.
// A start pulse at any time (re)starts the transfer from byte 0.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-clock FF46 write strobe
//   start_val     : value written to FF46
//   src_a, src_rd : source bus address / read strobe
//   src_dout      : source data, valid SRC_LATENCY clocks after src_rd
//   idx           : current byte index (0..OAM_BYTES-1)
//   data          : captured source byte for the current WRITE
//   write         : high during the WRITE state
//   active        : high whenever the engine is not idle (owns OAM)
//   state         : FSM state (debug)
module oam_dma_engine
    import oam_dma_arbiter_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int SRC_LATENCY     = 1,
    parameter int START_DELAY     = 4,
    parameter int OAM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  start_val,
    output logic [15:0] src_a,
    output logic        src_rd,
    input  logic [7:0]  src_dout,
    output logic [7:0]  idx,
    output logic [7:0]  data,
    output logic        write,
    output logic        active,
    output logic [2:0]  state
);

    // Clocks left in the byte slot after READ, WAIT and WRITE.
    localparam int PAD_CYCLES = CYCLES_PER_BYTE - 2 - SRC_LATENCY;

    logic [7:0] cnt;
    logic [7:0] src_hi;
    logic       last_byte;

    assign last_byte = (idx == 8'(OAM_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= 8'd0;
            idx    <= 8'd0;
            src_hi <= 8'd0;
            data   <= 8'd0;
        end else if (start) begin
            // A write to FF46 wins over whatever the FSM was doing.
            state  <= ST_DELAY;
            cnt    <= 8'(START_DELAY - 1);
            idx    <= 8'd0;
            src_hi <= fold_src_hi(start_val);
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_DELAY: begin
                    if (cnt == 8'd0) state <= ST_READ;
                    else             cnt   <= cnt - 8'd1;
                end
                ST_READ: begin
                    state <= ST_WAIT;
                    cnt   <= 8'(SRC_LATENCY - 1);
                end
                ST_WAIT: begin
                    // Capture on the last WAIT clock so the write does not
                    // depend on the source holding its data any longer.
                    if (cnt == 8'd0) begin
                        data  <= src_dout;
                        state <= ST_WRITE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (PAD_CYCLES == 0) begin
                        if (last_byte) begin
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= ST_READ;
                        end
                    end else begin
                        state <= ST_PAD;
                        cnt   <= 8'(PAD_CYCLES - 1);
                    end
                end
                ST_PAD: begin
                    if (cnt == 8'd0) begin
                        if (last_byte) begin
                            state <= ST_IDLE;
                        end else begin
                            idx   <= idx + 8'd1;
                            state <= ST_READ;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign src_a  = {src_hi, idx};
    assign src_rd = (state == ST_READ);
    assign write  = (state == ST_WRITE);
    assign active = (state != ST_IDLE);

endmodule

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
// Owns the OAM port and shares it between OAM DMA, the PPU and the CPU with
// fixed priority DMA > PPU > CPU, evaluated every clock. Holds the FF46
// register and starts the DMA engine on each write to it.
// Handshake: all strobes (cpu_wr, src_rd, oam_wr) are single-clock qualifiers
// with no back-pressure; a CPU OAM access while another requester owns the
// port is simply dropped (write) or answered with 0xFF (read).
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_a/cpu_din/cpu_wr/cpu_rd : CPU bus side
//   cpu_dout                 : FF46 value, OAM data (0xFF when blocked), else 0x00
//   src_a/src_rd/src_dout    : DMA source bus
//   ppu_mode/ppu_oam_a       : PPU mode and OAM read address
//   ppu_oam_dout             : OAM data to PPU (0xFF when the PPU does not own the port)
//   oam_a/oam_din/oam_wr/oam_dout : OAM RAM port
//   dma_active               : high while a transfer is in progress
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int SRC_LATENCY     = 1,
    parameter int START_DELAY     = 4,
    parameter int OAM_BYTES       = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_din,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    output logic [7:0]  cpu_dout,
    output logic [15:0] src_a,
    output logic        src_rd,
    input  logic [7:0]  src_dout,
    input  logic [1:0]  ppu_mode,
    input  logic [15:0] ppu_oam_a,
    output logic [7:0]  ppu_oam_dout,
    output logic [15:0] oam_a,
    output logic [7:0]  oam_din,
    output logic        oam_wr,
    input  logic [7:0]  oam_dout,
    output logic        dma_active
);

    logic [7:0] dma_reg;
    logic       dma_start;
    logic [7:0] dma_idx;
    logic [7:0] dma_data;
    logic       dma_write;
    logic [2:0] dma_state;
    logic       cpu_in_oam;
    ppu_mode_t  mode;
    oam_owner_t owner;

    // cpu_dout is decoded from cpu_a alone; the read strobe carries no state here.
    logic unused_cpu_rd;
    assign unused_cpu_rd = cpu_rd;

    assign mode       = ppu_mode_t'(ppu_mode);
    assign dma_start  = cpu_wr && (cpu_a == DMA_REG_ADDR);
    assign cpu_in_oam = (cpu_a >= OAM_BASE) && (cpu_a <= OAM_END);

    always_ff @(posedge clk) begin
        if (rst)            dma_reg <= 8'h00;
        else if (dma_start) dma_reg <= cpu_din;
    end

    oam_dma_engine #(
        .CYCLES_PER_BYTE (CYCLES_PER_BYTE),
        .SRC_LATENCY     (SRC_LATENCY),
        .START_DELAY     (START_DELAY),
        .OAM_BYTES       (OAM_BYTES)
    ) u_engine (
        .clk       (clk),
        .rst       (rst),
        .start     (dma_start),
        .start_val (cpu_din),
        .src_a     (src_a),
        .src_rd    (src_rd),
        .src_dout  (src_dout),
        .idx       (dma_idx),
        .data      (dma_data),
        .write     (dma_write),
        .active    (dma_active),
        .state     (dma_state)
    );

    always_comb begin
        owner = OWN_CPU;
        if (dma_state != ST_IDLE)                   owner = OWN_DMA;
        else if (mode == MODE_2 || mode == MODE_3)  owner = OWN_PPU;
    end

    always_comb begin
        oam_a        = OAM_BASE;
        oam_din      = 8'h00;
        oam_wr       = 1'b0;
        ppu_oam_dout = 8'hFF;
        cpu_dout     = 8'h00;

        case (owner)
            OWN_DMA: begin
                oam_a   = OAM_BASE + {8'h00, dma_idx};
                oam_din = dma_data;
                oam_wr  = dma_write;
            end
            OWN_PPU: begin
                oam_a        = ppu_oam_a;
                ppu_oam_dout = oam_dout;
            end
            default: begin
                // FEA0-FEFF is unusable space: the CPU never reaches the RAM there.
                if (cpu_in_oam) begin
                    oam_a = cpu_a;
                    if (cpu_wr) begin
                        oam_wr  = 1'b1;
                        oam_din = cpu_din;
                    end
                end
            end
        endcase

        if (cpu_a == DMA_REG_ADDR) cpu_dout = dma_reg;
        else if (cpu_in_oam)       cpu_dout = (owner == OWN_CPU) ? oam_dout : 8'hFF;
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Testbench for oam_dma_arbiter: idle-time arbitration vectors from a table,
// then hand-written DMA transfers (normal, echo fold, restart, reset abort).
module tb_oam_dma_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_din;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_dout;
    logic [15:0] src_a;
    logic        src_rd;
    logic [7:0]  src_dout;
    logic [1:0]  ppu_mode;
    logic [15:0] ppu_oam_a;
    logic [7:0]  ppu_oam_dout;
    logic [15:0] oam_a;
    logic [7:0]  oam_din;
    logic        oam_wr;
    logic [7:0]  oam_dout;
    logic        dma_active;

    int checks = 0;
    int errors = 0;

    logic [7:0] sys_mem [65536];
    logic [7:0] oam_mem [160];

    oam_dma_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_a        (cpu_a),
        .cpu_din      (cpu_din),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_dout     (cpu_dout),
        .src_a        (src_a),
        .src_rd       (src_rd),
        .src_dout     (src_dout),
        .ppu_mode     (ppu_mode),
        .ppu_oam_a    (ppu_oam_a),
        .ppu_oam_dout (ppu_oam_dout),
        .oam_a        (oam_a),
        .oam_din      (oam_din),
        .oam_wr       (oam_wr),
        .oam_dout     (oam_dout),
        .dma_active   (dma_active)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- memory models ----------------
    // System bus: one clock of read latency.
    initial src_dout = 8'h00;
    always @(posedge clk) if (src_rd) src_dout <= sys_mem[src_a];

    // OAM RAM: combinational read, synchronous write.
    assign oam_dout = (oam_a >= 16'hFE00 && oam_a <= 16'hFE9F) ? oam_mem[8'(oam_a - 16'hFE00)] : 8'h00;
    always @(posedge clk) begin
        if (oam_wr && oam_a >= 16'hFE00 && oam_a <= 16'hFE9F)
            oam_mem[8'(oam_a - 16'hFE00)] <= oam_din;
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_a   = a;
        cpu_din = d;
        cpu_wr  = 1'b1;
        @(negedge clk);
        cpu_wr  = 1'b0;
    endtask

    // Follows a transfer one negedge at a time until dma_active drops.
    task automatic dma_watch(input logic [7:0] exp_hi, input logic [7:0] exp_reg,
                             output int cycles, output int first_rd, output int reads,
                             output int bad_src, output int bad_port);
        cycles = 0; first_rd = 0; reads = 0; bad_src = 0; bad_port = 0;
        while (dma_active && cycles < 2000) begin
            cycles++;
            if (src_rd) begin
                if (first_rd == 0) first_rd = cycles;
                if (src_a !== {exp_hi, 8'(reads)}) bad_src++;
                reads++;
            end
            if (ppu_oam_dout !== 8'hFF || cpu_dout !== exp_reg) bad_port++;
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] pat(input logic [7:0] hi, input logic [7:0] i);
        case (hi)
            8'hC0:   return 8'hA0 ^ i;
            8'hC1:   return i;
            8'hC2:   return i ^ 8'h5A;
            8'hD0:   return ~i;
            default: return 8'h00;
        endcase
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] a;
        logic [7:0]  din;
        logic        wr;
        logic [1:0]  mode;
        logic [15:0] pa;
        logic [7:0]  exp_cpu;
        logic [7:0]  exp_ppu;
        logic [15:0] exp_oam_a;
        logic        exp_oam_wr;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int cyc, frd, nrd, bsrc, bport, bad, wcnt, guard;

        //            a         din    wr  mode pa        cpu    ppu    oam_a     wr
        vecs[0]  = '{16'hFE10, 8'h33, 1, 2'd0, 16'hFE20, 8'hEE, 8'hFF, 16'hFE10, 1};
        vecs[1]  = '{16'hFE10, 8'h00, 0, 2'd0, 16'hFE20, 8'h33, 8'hFF, 16'hFE10, 0};
        vecs[2]  = '{16'hFE10, 8'h00, 0, 2'd2, 16'hFE20, 8'hFF, 8'hEE, 16'hFE20, 0};
        vecs[3]  = '{16'hFE10, 8'h55, 1, 2'd2, 16'hFE20, 8'hFF, 8'hEE, 16'hFE20, 0};
        vecs[4]  = '{16'hFE10, 8'h00, 0, 2'd0, 16'hFE20, 8'h33, 8'hFF, 16'hFE10, 0};
        vecs[5]  = '{16'hFE9F, 8'h00, 0, 2'd3, 16'hFE05, 8'hFF, 8'hEE, 16'hFE05, 0};
        vecs[6]  = '{16'hFE9F, 8'h00, 0, 2'd0, 16'hFE05, 8'hEE, 8'hFF, 16'hFE9F, 0};
        vecs[7]  = '{16'hFEA0, 8'h99, 1, 2'd0, 16'hFE05, 8'h00, 8'hFF, 16'hFE00, 0};
        vecs[8]  = '{16'hFF46, 8'h00, 0, 2'd1, 16'hFE05, 8'h00, 8'hFF, 16'hFE00, 0};
        vecs[9]  = '{16'hC000, 8'h00, 0, 2'd0, 16'hFE05, 8'h00, 8'hFF, 16'hFE00, 0};
        vecs[10] = '{16'hFE9F, 8'h77, 1, 2'd1, 16'hFE05, 8'hEE, 8'hFF, 16'hFE9F, 1};
        vecs[11] = '{16'hFE9F, 8'h00, 0, 2'd0, 16'hFE05, 8'h77, 8'hFF, 16'hFE9F, 0};

        for (int i = 0; i < 65536; i++) sys_mem[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 160; i++) begin
            sys_mem[16'hC000 + i] = pat(8'hC0, 8'(i));
            sys_mem[16'hC100 + i] = pat(8'hC1, 8'(i));
            sys_mem[16'hC200 + i] = pat(8'hC2, 8'(i));
            sys_mem[16'hD000 + i] = pat(8'hD0, 8'(i));
            oam_mem[i] = 8'hEE;
        end

        // ---------------- reset ----------------
        rst = 1'b1; cpu_a = 16'h0000; cpu_din = 8'h00; cpu_wr = 1'b0; cpu_rd = 1'b0;
        ppu_mode = 2'd0; ppu_oam_a = 16'hFE00;
        repeat (3) @(negedge clk);
        check("rst_src_rd", 16'(src_rd), 16'h0);
        check("rst_oam_wr", 16'(oam_wr), 16'h0);
        check("rst_dma_active", 16'(dma_active), 16'h0);
        check("rst_src_a", src_a, 16'h0000);
        check("rst_oam_a", oam_a, 16'hFE00);
        check("rst_oam_din", 16'(oam_din), 16'h00);
        check("rst_cpu_dout", 16'(cpu_dout), 16'h00);
        check("rst_ppu_dout", 16'(ppu_oam_dout), 16'hFF);
        rst = 1'b0;

        // ---------------- idle arbitration table ----------------
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            cpu_a = vecs[i].a; cpu_din = vecs[i].din; cpu_wr = vecs[i].wr;
            ppu_mode = vecs[i].mode; ppu_oam_a = vecs[i].pa;
            #1;
            check($sformatf("vec%0d_cpu_dout", i), 16'(cpu_dout), 16'(vecs[i].exp_cpu));
            check($sformatf("vec%0d_ppu_dout", i), 16'(ppu_oam_dout), 16'(vecs[i].exp_ppu));
            check($sformatf("vec%0d_oam_a", i), oam_a, vecs[i].exp_oam_a);
            check($sformatf("vec%0d_oam_wr", i), 16'(oam_wr), 16'(vecs[i].exp_oam_wr));
        end
        @(negedge clk);
        cpu_wr = 1'b0; ppu_mode = 2'd0;

        // ---------------- transfer from C1xx ----------------
        ppu_mode = 2'd3;
        cpu_write(16'hFF46, 8'hC1);
        dma_watch(8'hC1, 8'hC1, cyc, frd, nrd, bsrc, bport);
        check("t1_active_cycles", 16'(cyc), 16'd644);
        check("t1_first_read", 16'(frd), 16'd5);
        check("t1_reads", 16'(nrd), 16'd160);
        check("t1_src_a", 16'(bsrc), 16'd0);
        check("t1_ppu_blocked_ff46", 16'(bport), 16'd0);
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam_mem[i] !== pat(8'hC1, 8'(i))) bad++;
        check("t1_oam_bad_bytes", 16'(bad), 16'd0);
        ppu_mode = 2'd0;
        @(negedge clk);
        check("t1_ff46_after", 16'(cpu_dout), 16'hC1);

        // ---------------- echo fold E2 -> C2 ----------------
        cpu_write(16'hFF46, 8'hE2);
        dma_watch(8'hC2, 8'hE2, cyc, frd, nrd, bsrc, bport);
        check("t2_active_cycles", 16'(cyc), 16'd644);
        check("t2_reads", 16'(nrd), 16'd160);
        check("t2_src_a_folded", 16'(bsrc), 16'd0);
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam_mem[i] !== pat(8'hC2, 8'(i))) bad++;
        check("t2_oam_bad_bytes", 16'(bad), 16'd0);

        // ---------------- restart after 50 bytes ----------------
        cpu_write(16'hFF46, 8'hC0);
        wcnt = 0; guard = 0;
        while (wcnt < 50 && guard < 1000) begin
            if (oam_wr) wcnt++;
            guard++;
            @(negedge clk);
        end
        check("t4_bytes_before_restart", 16'(wcnt), 16'd50);
        cpu_write(16'hFF46, 8'hD0);
        check("t4_active_after_restart", 16'(dma_active), 16'h1);
        dma_watch(8'hD0, 8'hD0, cyc, frd, nrd, bsrc, bport);
        check("t4_active_cycles", 16'(cyc), 16'd644);
        check("t4_first_read", 16'(frd), 16'd5);
        check("t4_src_a", 16'(bsrc), 16'd0);
        bad = 0;
        for (int i = 0; i < 160; i++) if (oam_mem[i] !== pat(8'hD0, 8'(i))) bad++;
        check("t4_oam_bad_bytes", 16'(bad), 16'd0);

        // ---------------- reset mid-transfer ----------------
        cpu_write(16'hFF46, 8'hC1);
        wcnt = 0; guard = 0;
        while (guard < 1000) begin
            if (oam_wr) begin
                wcnt++;
                if (wcnt == 80) break;
            end
            guard++;
            @(negedge clk);
        end
        check("t5_bytes_before_reset", 16'(wcnt), 16'd80);
        rst = 1'b1;
        @(negedge clk);
        check("t5_oam_wr", 16'(oam_wr), 16'h0);
        check("t5_dma_active", 16'(dma_active), 16'h0);
        check("t5_src_rd", 16'(src_rd), 16'h0);
        check("t5_ff46", 16'(cpu_dout), 16'h00);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("t5_stays_idle", 16'(dma_active), 16'h0);
        bad = 0;
        for (int i = 0; i < 80; i++) if (oam_mem[i] !== pat(8'hC1, 8'(i))) bad++;
        check("t5_low_bytes_bad", 16'(bad), 16'd0);
        bad = 0;
        for (int i = 80; i < 160; i++) if (oam_mem[i] !== pat(8'hD0, 8'(i))) bad++;
        check("t5_high_bytes_bad", 16'(bad), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
